// File: rtl/mem_access_stage.sv
// mem_access_stage: MEM stage of the pipelined MIPS datapath.
// Resolves the branch, runs loads/stores against data memory over a
// req/ack handshake, stalls upstream while an access is outstanding and
// drives the MEM/WB pipeline register.
// Optional feature macro: MEM_TIMEOUT_EN (abort an access after
// TIMEOUT_CYCLES ACCESS cycles without ack; sets the sticky mem_err flag).
module mem_access_stage #(
  parameter int TIMEOUT_CYCLES = 16,
  parameter int CNT_W          = 5
) (
  input  logic        clk,
  input  logic        rst,
  input  logic [31:0] pcAdder,
  input  logic        zeroflag,
  input  logic [31:0] Alu_result,
  input  logic [31:0] DataWrite,
  input  logic [4:0]  muxRegFileD,
  input  logic        branch,
  input  logic        memtoWrite,
  input  logic        memtoRead,
  input  logic        regWrite,
  input  logic        memtoReg,
  output logic        stall,
  output logic        pcSrc,
  output logic [31:0] branchTarget,
  output logic        dm_req,
  output logic        dm_we,
  output logic [31:0] dm_addr,
  output logic [31:0] dm_wdata,
  input  logic [31:0] dm_rdata,
  input  logic        dm_ack,
  output logic [31:0] outReadData,
  output logic [31:0] outAlu_Result,
  output logic [4:0]  outmuxRegFileD,
  output logic        outregWrite,
  output logic        outmemtoReg,
  output logic        align_err,
  output logic        mem_err
);

  typedef enum logic [0:0] {
    ST_IDLE   = 1'b0,
    ST_ACCESS = 1'b1
  } state_t;

  // Elaboration-time sanity check: the timeout counter must be able to hold the limit.
  generate
    if ((TIMEOUT_CYCLES < 1) || (TIMEOUT_CYCLES >= (1 << CNT_W))) begin : g_bad_cfg
      $error("mem_access_stage: CNT_W too small for TIMEOUT_CYCLES");
    end
  endgenerate

  state_t      state_q, state_d;
  logic        dm_req_q, dm_req_d;
  logic        dm_we_q, dm_we_d;
  logic [31:0] dm_addr_q, dm_addr_d;
  logic [31:0] dm_wdata_q, dm_wdata_d;
  logic [31:0] rdata_q, rdata_d;
  logic [31:0] alu_q, alu_d;
  logic [4:0]  rd_q, rd_d;
  logic        regwrite_q, regwrite_d;
  logic        memtoreg_q, memtoreg_d;
  logic        align_err_q, align_err_d;

  logic        acc_s;
  logic        misalign_s;
  logic        aligned_acc_s;
  logic        tmo_hit_s;

`ifdef MEM_TIMEOUT_EN
  logic [CNT_W-1:0] cnt_q, cnt_d;
  logic             mem_err_q, mem_err_d;

  // Timeout fires on the last permitted ACCESS cycle without ack.
  always_comb begin
    tmo_hit_s = 1'b0;
    if ((state_q == ST_ACCESS) && (cnt_q == CNT_W'(TIMEOUT_CYCLES - 1))) begin
      tmo_hit_s = 1'b1;
    end else begin
      tmo_hit_s = 1'b0;
    end
  end
`else
  assign tmo_hit_s = 1'b0;
`endif

  assign acc_s         = memtoRead | memtoWrite;
  assign misalign_s    = acc_s & (Alu_result[1:0] != 2'b00);
  assign aligned_acc_s = acc_s & ~misalign_s;

  // Branch resolution and upstream stall; every output reads 0 while reset is held.
  always_comb begin
    pcSrc        = 1'b0;
    branchTarget = 32'h0000_0000;
    stall        = 1'b0;
    if (rst) begin
      pcSrc        = 1'b0;
      branchTarget = 32'h0000_0000;
      stall        = 1'b0;
    end else begin
      pcSrc        = branch & zeroflag;
      branchTarget = pcAdder;
      stall        = ((state_q == ST_IDLE) & aligned_acc_s) |
                     ((state_q == ST_ACCESS) & ~dm_ack & ~tmo_hit_s);
    end
  end

  // Next-state logic: FSM, memory port, MEM/WB register (bubble by default).
  always_comb begin
    state_d     = state_q;
    dm_req_d    = dm_req_q;
    dm_we_d     = dm_we_q;
    dm_addr_d   = dm_addr_q;
    dm_wdata_d  = dm_wdata_q;
    rdata_d     = 32'h0000_0000;
    alu_d       = Alu_result;
    rd_d        = muxRegFileD;
    regwrite_d  = 1'b0;
    memtoreg_d  = 1'b0;
    align_err_d = 1'b0;
`ifdef MEM_TIMEOUT_EN
    cnt_d       = cnt_q;
    mem_err_d   = mem_err_q;
`endif
    case (state_q)
      ST_IDLE: begin
        if (misalign_s) begin
          align_err_d = 1'b1;
        end else if (aligned_acc_s) begin
          // A read+write combination is treated as a write.
          dm_req_d   = 1'b1;
          dm_we_d    = memtoWrite;
          dm_addr_d  = Alu_result;
          dm_wdata_d = DataWrite;
          state_d    = ST_ACCESS;
`ifdef MEM_TIMEOUT_EN
          cnt_d      = {CNT_W{1'b0}};
`endif
        end else begin
          regwrite_d = regWrite;
          memtoreg_d = memtoReg;
        end
      end
      ST_ACCESS: begin
        if (dm_ack) begin
          if (!dm_we_q) begin
            rdata_d = dm_rdata;
          end else begin
            rdata_d = 32'h0000_0000;
          end
          regwrite_d = regWrite;
          memtoreg_d = memtoReg;
          dm_req_d   = 1'b0;
          state_d    = ST_IDLE;
        end else if (tmo_hit_s) begin
          dm_req_d = 1'b0;
          state_d  = ST_IDLE;
`ifdef MEM_TIMEOUT_EN
          mem_err_d = 1'b1;
`endif
        end else begin
`ifdef MEM_TIMEOUT_EN
          cnt_d = cnt_q + CNT_W'(1);
`endif
        end
      end
      default: begin
        state_d  = ST_IDLE;
        dm_req_d = 1'b0;
      end
    endcase
  end

  // State and output registers with asynchronous reset.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state_q     <= ST_IDLE;
      dm_req_q    <= 1'b0;
      dm_we_q     <= 1'b0;
      dm_addr_q   <= 32'h0000_0000;
      dm_wdata_q  <= 32'h0000_0000;
      rdata_q     <= 32'h0000_0000;
      alu_q       <= 32'h0000_0000;
      rd_q        <= 5'd0;
      regwrite_q  <= 1'b0;
      memtoreg_q  <= 1'b0;
      align_err_q <= 1'b0;
`ifdef MEM_TIMEOUT_EN
      cnt_q       <= {CNT_W{1'b0}};
      mem_err_q   <= 1'b0;
`endif
    end else begin
      state_q     <= state_d;
      dm_req_q    <= dm_req_d;
      dm_we_q     <= dm_we_d;
      dm_addr_q   <= dm_addr_d;
      dm_wdata_q  <= dm_wdata_d;
      rdata_q     <= rdata_d;
      alu_q       <= alu_d;
      rd_q        <= rd_d;
      regwrite_q  <= regwrite_d;
      memtoreg_q  <= memtoreg_d;
      align_err_q <= align_err_d;
`ifdef MEM_TIMEOUT_EN
      cnt_q       <= cnt_d;
      mem_err_q   <= mem_err_d;
`endif
    end
  end

  assign dm_req         = dm_req_q;
  assign dm_we          = dm_we_q;
  assign dm_addr        = dm_addr_q;
  assign dm_wdata       = dm_wdata_q;
  assign outReadData    = rdata_q;
  assign outAlu_Result  = alu_q;
  assign outmuxRegFileD = rd_q;
  assign outregWrite    = regwrite_q;
  assign outmemtoReg    = memtoreg_q;
  assign align_err      = align_err_q;
`ifdef MEM_TIMEOUT_EN
  assign mem_err        = mem_err_q;
`else
  assign mem_err        = 1'b0;
`endif

endmodule

// File: tb/tb_mem_access_stage.sv
// Directed self-checking bench for mem_access_stage.
module tb_mem_access_stage;

  logic        clk;
  logic        rst;
  logic [31:0] pcAdder;
  logic        zeroflag;
  logic [31:0] Alu_result;
  logic [31:0] DataWrite;
  logic [4:0]  muxRegFileD;
  logic        branch, memtoWrite, memtoRead, regWrite, memtoReg;
  logic        stall, pcSrc;
  logic [31:0] branchTarget;
  logic        dm_req, dm_we;
  logic [31:0] dm_addr, dm_wdata, dm_rdata;
  logic        dm_ack;
  logic [31:0] outReadData, outAlu_Result;
  logic [4:0]  outmuxRegFileD;
  logic        outregWrite, outmemtoReg, align_err, mem_err;

  int n_checks = 0;
  int n_fail   = 0;
  int stall_cnt;

  mem_access_stage #(.TIMEOUT_CYCLES(16), .CNT_W(5)) dut (
    .clk(clk), .rst(rst), .pcAdder(pcAdder), .zeroflag(zeroflag),
    .Alu_result(Alu_result), .DataWrite(DataWrite), .muxRegFileD(muxRegFileD),
    .branch(branch), .memtoWrite(memtoWrite), .memtoRead(memtoRead),
    .regWrite(regWrite), .memtoReg(memtoReg), .stall(stall), .pcSrc(pcSrc),
    .branchTarget(branchTarget), .dm_req(dm_req), .dm_we(dm_we),
    .dm_addr(dm_addr), .dm_wdata(dm_wdata), .dm_rdata(dm_rdata),
    .dm_ack(dm_ack), .outReadData(outReadData), .outAlu_Result(outAlu_Result),
    .outmuxRegFileD(outmuxRegFileD), .outregWrite(outregWrite),
    .outmemtoReg(outmemtoReg), .align_err(align_err), .mem_err(mem_err)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_checks++;
    assert (obs === exp) else begin
      n_fail++;
      $error("FAIL %s observed=%h expected=%h", tag, obs, exp);
    end
  endtask

  // Advance to 1 time unit after the next rising edge.
  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic nop();
    pcAdder = 32'h0; zeroflag = 1'b0; Alu_result = 32'h0; DataWrite = 32'h0;
    muxRegFileD = 5'd0; branch = 1'b0; memtoWrite = 1'b0; memtoRead = 1'b0;
    regWrite = 1'b0; memtoReg = 1'b0; dm_ack = 1'b0; dm_rdata = 32'h0;
  endtask

  initial begin
    rst = 1'b1;
    nop();
    branch = 1'b1; zeroflag = 1'b1; pcAdder = 32'h0000_0040;
    #12;
    // Reset state: everything 0 even with a taken branch on the inputs.
    chk("rst_pcSrc", {31'd0, pcSrc}, 32'd0);
    chk("rst_stall", {31'd0, stall}, 32'd0);
    chk("rst_dm_req", {31'd0, dm_req}, 32'd0);
    chk("rst_outregWrite", {31'd0, outregWrite}, 32'd0);
    chk("rst_mem_err", {31'd0, mem_err}, 32'd0);
    rst = 1'b0;
    #1;
    // Branch taken, same cycle, no stall.
    chk("br_pcSrc", {31'd0, pcSrc}, 32'd1);
    chk("br_target", branchTarget, 32'h0000_0040);
    chk("br_stall", {31'd0, stall}, 32'd0);
    zeroflag = 1'b0;
    #1;
    chk("br_not_taken", {31'd0, pcSrc}, 32'd0);

    // Non-memory ALU op: MEM/WB one cycle later.
    tick();
    nop();
    Alu_result = 32'h0000_0055; muxRegFileD = 5'd7; regWrite = 1'b1;
    #1;
    chk("alu_stall", {31'd0, stall}, 32'd0);
    tick();
    chk("alu_out", outAlu_Result, 32'h0000_0055);
    chk("alu_rd", {27'd0, outmuxRegFileD}, 32'd7);
    chk("alu_regwrite", {31'd0, outregWrite}, 32'd1);
    chk("alu_rdata", outReadData, 32'h0);

    // Load from 0x100, ack after three wait cycles.
    nop();
    Alu_result = 32'h0000_0100; memtoRead = 1'b1; memtoReg = 1'b1;
    regWrite = 1'b1; muxRegFileD = 5'd9;
    stall_cnt = 0;
    #1;
    if (stall) stall_cnt++;
    tick();
    chk("ld_req", {31'd0, dm_req}, 32'd1);
    chk("ld_we", {31'd0, dm_we}, 32'd0);
    chk("ld_addr", dm_addr, 32'h0000_0100);
    chk("ld_bubble", {31'd0, outregWrite}, 32'd0);
    for (int i = 0; i < 3; i++) begin
      if (stall) stall_cnt++;
      tick();
      chk("ld_req_hold", {31'd0, dm_req}, 32'd1);
    end
    dm_ack = 1'b1; dm_rdata = 32'hDEAD_BEEF;
    #1;
    chk("ld_ack_stall", {31'd0, stall}, 32'd0);
    chk("ld_stall_cycles", stall_cnt, 32'd4);
    tick();
    nop();
    #1;
    chk("ld_rdata", outReadData, 32'hDEAD_BEEF);
    chk("ld_regwrite", {31'd0, outregWrite}, 32'd1);
    chk("ld_memtoreg", {31'd0, outmemtoReg}, 32'd1);
    chk("ld_rd", {27'd0, outmuxRegFileD}, 32'd9);
    chk("ld_req_drop", {31'd0, dm_req}, 32'd0);
    tick();
    chk("ld_no_dup", {31'd0, outregWrite}, 32'd0);

    // Store to 0x104, ack in the first ACCESS cycle.
    Alu_result = 32'h0000_0104; DataWrite = 32'h1234_5678; memtoWrite = 1'b1;
    #1;
    chk("st_stall_idle", {31'd0, stall}, 32'd1);
    tick();
    chk("st_we", {31'd0, dm_we}, 32'd1);
    chk("st_addr", dm_addr, 32'h0000_0104);
    chk("st_wdata", dm_wdata, 32'h1234_5678);
    dm_ack = 1'b1; dm_rdata = 32'hAAAA_5555;
    #1;
    chk("st_stall_ack", {31'd0, stall}, 32'd0);
    tick();
    nop();
    #1;
    chk("st_req_drop", {31'd0, dm_req}, 32'd0);
    chk("st_rdata_zero", outReadData, 32'h0);

    // Misaligned load at 0x102.
    Alu_result = 32'h0000_0102; memtoRead = 1'b1; regWrite = 1'b1; memtoReg = 1'b1;
    #1;
    chk("mis_stall", {31'd0, stall}, 32'd0);
    tick();
    nop();
    #1;
    chk("mis_align_err", {31'd0, align_err}, 32'd1);
    chk("mis_no_req", {31'd0, dm_req}, 32'd0);
    chk("mis_regwrite", {31'd0, outregWrite}, 32'd0);
    tick();
    chk("mis_pulse_end", {31'd0, align_err}, 32'd0);

    // Read+write together at 0x108 acts as a write with zero read data.
    Alu_result = 32'h0000_0108; memtoRead = 1'b1; memtoWrite = 1'b1; regWrite = 1'b1;
    tick();
    chk("rw_we", {31'd0, dm_we}, 32'd1);
    dm_ack = 1'b1; dm_rdata = 32'hCAFE_F00D;
    tick();
    // Back-to-back: second load's IDLE cycle follows the ack edge directly.
    nop();
    Alu_result = 32'h0000_0200; memtoRead = 1'b1; regWrite = 1'b1;
    #1;
    chk("rw_rdata_zero", outReadData, 32'h0);
    chk("b2b_stall", {31'd0, stall}, 32'd1);
    tick();
    chk("b2b_req", {31'd0, dm_req}, 32'd1);
    chk("b2b_addr", dm_addr, 32'h0000_0200);

    // Reset in the middle of ACCESS.
    rst = 1'b1;
    #1;
    chk("mid_rst_req", {31'd0, dm_req}, 32'd0);
    chk("mid_rst_stall", {31'd0, stall}, 32'd0);
    chk("mid_rst_alu", outAlu_Result, 32'h0);
    chk("mid_rst_regwrite", {31'd0, outregWrite}, 32'd0);
    tick();
    rst = 1'b0;
    nop();
    Alu_result = 32'h0000_0077; regWrite = 1'b1;
    #1;
    chk("post_rst_stall", {31'd0, stall}, 32'd0);
    tick();
    chk("post_rst_alu", outAlu_Result, 32'h0000_0077);
    chk("post_rst_req", {31'd0, dm_req}, 32'd0);

`ifdef MEM_TIMEOUT_EN
    // Load with no ack: aborted after 16 ACCESS cycles.
    nop();
    Alu_result = 32'h0000_0300; memtoRead = 1'b1; regWrite = 1'b1;
    tick();
    for (int i = 0; i < 15; i++) begin
      chk("tmo_req_hold", {31'd0, dm_req}, 32'd1);
      chk("tmo_stall", {31'd0, stall}, 32'd1);
      tick();
    end
    chk("tmo_last_req", {31'd0, dm_req}, 32'd1);
    chk("tmo_release", {31'd0, stall}, 32'd0);
    tick();
    nop();
    Alu_result = 32'h0000_0011; regWrite = 1'b1;
    #1;
    chk("tmo_req_drop", {31'd0, dm_req}, 32'd0);
    chk("tmo_mem_err", {31'd0, mem_err}, 32'd1);
    chk("tmo_bubble", {31'd0, outregWrite}, 32'd0);
    tick();
    chk("tmo_next_alu", outAlu_Result, 32'h0000_0011);
    chk("tmo_next_rw", {31'd0, outregWrite}, 32'd1);
    chk("tmo_sticky", {31'd0, mem_err}, 32'd1);
`else
    chk("no_tmo_mem_err", {31'd0, mem_err}, 32'd0);
`endif

    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule

// File: doc/mem_access_stage.md
# mem_access_stage

Memory stage of the pipelined MIPS datapath; it consumes the EX/MEM pipeline register outputs. It resolves the branch decision, runs each load/store against the data memory over a req/ack handshake, and stalls upstream while an access is outstanding. It then drives the MEM/WB pipeline register toward write-back.

## Interface
Parameters:
- `TIMEOUT_CYCLES`, default 16: cycles in ACCESS without ack before abort; only used with `MEM_TIMEOUT_EN`.
- `CNT_W`, default 5: width of the timeout counter; must hold `TIMEOUT_CYCLES`.

Ports:
- `clk` in 1: single clock; everything is on the rising edge.
- `rst` in 1: asynchronous, active-high reset.
- `pcAdder` in 32: branch target from EX/MEM.
- `zeroflag` in 1: ALU zero flag from EX/MEM.
- `Alu_result` in 32: ALU result from EX/MEM; this is the memory byte address.
- `DataWrite` in 32: store data.
- `muxRegFileD` in 5: destination register.
- `branch`, `memtoWrite`, `memtoRead`, `regWrite`, `memtoReg` in 1 each: control bits from EX/MEM.
- `stall` out 1: freeze upstream (PC, IF/ID, ID/EX, EX/MEM).
- `pcSrc` out 1: take the branch.
- `branchTarget` out 32: the target the PC loads when `pcSrc`=1.
- `dm_req` out 1: memory request.
- `dm_we` out 1: 1 = write, 0 = read.
- `dm_addr` out 32: memory byte address.
- `dm_wdata` out 32: write data to memory.
- `dm_rdata` in 32: read data from memory.
- `dm_ack` in 1: memory access complete.
- `outReadData` out 32, `outAlu_Result` out 32, `outmuxRegFileD` out 5, `outregWrite` out 1, `outmemtoReg` out 1: MEM/WB register outputs.
- `align_err` out 1: one-cycle pulse on a misaligned access.
- `mem_err` out 1: sticky timeout flag.

## Operation
- Combinational:
  - `pcSrc` = `branch` & `zeroflag`.
  - `branchTarget` = `pcAdder`.
  - Both are independent of FSM state.
- Access request: `acc` = `memtoRead` | `memtoWrite`.
- Misaligned access: `Alu_result[1:0]` != 0 with `acc`=1.
  - No memory request is issued.
  - `align_err` pulses for one cycle.
  - MEM/WB loads a bubble: `outregWrite`=0, `outmemtoReg`=0.
- `memtoRead` and `memtoWrite` both set: treated as a write; `outReadData`=0.
- FSM states IDLE and ACCESS:
  - IDLE with aligned `acc`: latch address/data/write-enable into `dm_*`, set `dm_req`=1, go to ACCESS.
  - IDLE otherwise: MEM/WB loads from the inputs, with `outReadData`=0.
  - ACCESS with `dm_ack`=1: on that edge, capture `dm_rdata` into `outReadData` (reads only), load the remaining MEM/WB fields from the held inputs, drop `dm_req`, return to IDLE.
  - ACCESS with `dm_ack`=0: hold all `dm_*` stable.
- `stall` = (IDLE & aligned `acc`) | (ACCESS & !`dm_ack`).
- While `stall`=1, MEM/WB loads a bubble (`outregWrite`=0, `outmemtoReg`=0) every cycle.
- Upstream must hold the EX/MEM inputs stable while `stall`=1.
- `dm_ack` is ignored whenever `dm_req`=0.
- Reset, asynchronous:
  - FSM returns to IDLE.
  - All outputs 0, including `dm_req`, `mem_err` and `align_err`.
  - An in-flight request is abandoned; memory must tolerate `dm_req` dropping without ack.

## Timing
- Non-memory instruction: MEM/WB valid 1 cycle after the inputs appear; no stall.
- Memory access with ack in the first ACCESS cycle: 2 cycles to MEM/WB.
- Each extra wait cycle adds 1 cycle of latency.
- `stall` is high from the IDLE detect cycle through the last ACCESS cycle without ack.
- `stall` falls in the ack cycle, so upstream advances on the same edge that loads MEM/WB.
- `dm_req` is registered and asserts 1 cycle after the access enters.
- Back-to-back loads: the second load's IDLE cycle directly follows the first load's ack edge. Minimum 2 cycles per access; no idle gap needed.

## Configuration
- `MEM_TIMEOUT_EN` defined:
  - A counter clears on entering ACCESS and increments each ACCESS cycle without ack.
  - When the count reaches `TIMEOUT_CYCLES`: drop `dm_req`, go to IDLE, set `mem_err`=1 (sticky until reset), load a MEM/WB bubble, release `stall`.
  - An ack in the same cycle as the count reaching the limit wins: normal completion, no error.
- Undefined: no counter; ACCESS waits indefinitely; `mem_err` tied to 0.

## Test plan
- Reset asserted mid-ACCESS, with `dm_req`=1 → `dm_req`, `stall` and all MEM/WB outputs 0 immediately; FSM in IDLE after reset release.
- Branch: `branch`=1, `zeroflag`=1, `pcAdder`=0x0000_0040 → `pcSrc`=1, `branchTarget`=0x40 in the same cycle; no stall.
- Load from 0x100, `dm_rdata`=0xDEADBEEF, ack after 3 wait cycles → `stall` high 4 cycles; `outReadData`=0xDEADBEEF, `outregWrite`=1, `outmuxRegFileD` passes through; only one MEM/WB write (no duplicate).
- Store to 0x104 with `DataWrite`=0x12345678, ack in the first ACCESS cycle → `dm_we`=1, `dm_addr`=0x104, `dm_wdata`=0x12345678; `stall` high 1 cycle.
- Load at 0x102 (misaligned) → no `dm_req`; `align_err` pulses 1 cycle; `outregWrite`=0.
- With `MEM_TIMEOUT_EN` and `TIMEOUT_CYCLES`=16, no ack ever → `dm_req` drops after 16 ACCESS cycles; `mem_err`=1 and stays set; `stall` releases; the next instruction proceeds normally.
